// File: rtl/risc16_pkg.sv
// Shared constants for the 16-bit RISC core.
// Used by fetch, core and control unit.
package risc16_pkg;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP = 16'h0000;
  localparam int RESET_PC_DEF = 0;
endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch queue: word + pc per entry, flushable.
// Head is held in its own registers so it keeps its last value when empty.
module fetch_fifo
  import risc16_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_data,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [CW-1:0]      count,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_data,
  output logic [ADDR_W-1:0]  head_pc
);

  logic [INSTR_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q   [DEPTH];

  logic [PW-1:0]      rd_q, rd_d;
  logic [PW-1:0]      wr_q, wr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hv_q, hv_d;
  logic [INSTR_W-1:0] hdata_q, hdata_d;
  logic [ADDR_W-1:0]  hpc_q, hpc_d;

  // Pointer/count update and next head selection
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    hdata_d = hdata_q;
    hpc_d   = hpc_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + PW'(pop);
      wr_d  = wr_q + PW'(push);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    hv_d = (cnt_d != '0);
    if (hv_d) begin
      if (cnt_q == CW'(pop)) begin
        hdata_d = push_data;
        hpc_d   = push_pc;
      end else begin
        hdata_d = data_q[rd_d];
        hpc_d   = pc_q[rd_d];
      end
    end
  end

  // Entry storage write
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_q[wr_q] <= push_data;
      pc_q[wr_q]   <= push_pc;
    end
  end

  // Control and head registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      hv_q    <= 1'b0;
      hdata_q <= NOP;
      hpc_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      hv_q    <= hv_d;
      hdata_q <= hdata_d;
      hpc_q   <= hpc_d;
    end
  end

  assign count      = cnt_q;
  assign head_valid = hv_q;
  assign head_data  = hdata_q;
  assign head_pc    = hpc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem request issue, kill on redirect.
// Returned words are queued in fetch_fifo and handed to the core.
module instr_fetch
  import risc16_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inflight_q, inflight_d;

  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          issue;
  logic          push;
  logic          pop;

  // Issue when the queue can absorb every outstanding word
  always_comb begin
    occ   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    issue = !reset && enable && !pc_load && (occ < DEPTH_V);
    push  = inflight_q && !pc_load;
    pop   = instr_valid && instr_ready;
    imem_req  = issue;
    imem_addr = reset ? RST_PC : fetch_pc_q;
  end

  // Next PC, in-flight flag and return address
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (pc_load) begin
      fetch_pc_d = pc_load_addr;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
    inflight_d = issue;
    req_addr_d = issue ? fetch_pc_q : req_addr_q;
  end

  // Fetch state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RST_PC;
      req_addr_q <= RST_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (imem_rdata),
    .push_pc    (req_addr_q),
    .pop        (pop),
    .flush      (pc_load),
    .count      (count),
    .head_valid (instr_valid),
    .head_data  (instruction),
    .head_pc    (instr_pc)
  );

endmodule
